rope_grab_controller: RTL and testbench
=======================================

# rope_grab_controller

Sequences the swinging ropes and arbitrates the monkey's grip on them. Sits between the rope display array and the monkey movement logic. Each cycle it:
- takes per-rope monkey collision flags and per-rope signed speeds;
- decides which single rope (if any) the monkey hangs on, and forwards that rope's speed as the carry velocity;
- handles jump-off with a per-rope re-grab cooldown;
- generates the periodic direction-toggle pulses that drive every rope's swing.

## Interface
- ROPES, 6, number of ropes handled (bit i refers to rope i everywhere)
- SWING_FRAMES, 60, frames between rope direction reversals (≥1)
- COOLDOWN_FRAMES, 15, frames during which the just-released rope cannot be re-grabbed (≥1)
- clk  in  1  system clock
- resetN  in  1  synchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per video frame
- monkeyCollision  in  ROPES  bit i = monkey overlaps rope i this cycle
- ropeSpeeds  in  ROPES×32  signed X speed of each rope
- jumpReq  in  1  monkey requests release (level, sampled each cycle)
- hanging  out  1  monkey currently attached to a rope
- ropeIdx  out  $clog2(ROPES)  index of attached rope (last attached when not hanging)
- carrySpeed  out  32  signed speed to apply to monkey; 0 when not hanging
- grabPulse  out  1  one-cycle pulse on each new attach
- dirToggle  out  ROPES  one-cycle pulse, all bits, on swing reversal

## Operation
- All outputs registered. Reset values:
  - hanging=0, ropeIdx=0, carrySpeed=0, grabPulse=0, dirToggle=0
  - state=FREE, frameCnt=0, coolCnt=0
- State machine FREE / HANGING / COOLDOWN.
- Arbitration: winner = lowest index set in the candidate mask.
- FREE:
  - candidate mask = monkeyCollision.
  - If non-zero → HANGING, latch ropeIdx=winner, carrySpeed=ropeSpeeds[winner], grabPulse=1.
  - jumpReq ignored.
- HANGING:
  - carrySpeed reloads ropeSpeeds[ropeIdx] every cycle.
  - Collisions with other ropes ignored.
  - jumpReq=1 → COOLDOWN, hanging=0, carrySpeed=0, coolCnt=COOLDOWN_FRAMES, ropeIdx held.
  - jumpReq has priority over everything in this state.
- COOLDOWN:
  - candidate mask = monkeyCollision with bit ropeIdx cleared.
  - If non-zero → HANGING on winner (as in FREE), coolCnt cleared. Grab takes priority over countdown in the same cycle.
  - Otherwise coolCnt decrements on each startOfFrame; on the startOfFrame where coolCnt==1 → FREE.
- Swing scheduler (independent of grab FSM):
  - frameCnt increments on startOfFrame.
  - On startOfFrame with frameCnt==SWING_FRAMES-1: frameCnt→0 and dirToggle=all ones for exactly one cycle.
- carrySpeed passes the full 32-bit signed value unmodified. No saturation or arithmetic.

## Timing
- Collision at cycle n (FREE) → at n+1: hanging=1, grabPulse=1, ropeIdx and carrySpeed valid. grabPulse=0 at n+2.
- While hanging, carrySpeed at n+1 equals ropeSpeeds[ropeIdx] sampled at n (1-cycle latency).
- jumpReq at n → hanging=0 and carrySpeed=0 at n+1.
- Cooldown length: exactly COOLDOWN_FRAMES startOfFrame pulses after entry. The pulse counting to zero makes the state FREE on the next cycle, so the released rope is grabbable from that cycle.
- dirToggle: the startOfFrame pulse at cycle n qualifies → dirToggle high at n+1 only. First toggle follows the SWING_FRAMES-th startOfFrame after reset.
- resetN=0 mid-hang or mid-cooldown → all reset values at next edge. No grabPulse or dirToggle is emitted from reset.
- startOfFrame and a grab in the same cycle: both are processed; the swing counter is unaffected by the FSM.

## Test plan
- Reset, monkeyCollision=6'b010100, ropeSpeeds[2]=-5 → one cycle later: hanging=1, ropeIdx=2, carrySpeed=-5, grabPulse=1 for 1 cycle.
- Hanging on rope 2, change ropeSpeeds[2] to +7 and assert collision on rope 0 → carrySpeed=+7 next cycle, ropeIdx stays 2.
- Hanging on rope 2, jumpReq=1 with collision only on rope 2 for 15 frames → hanging stays 0. After the 15th startOfFrame, the next cycle FREE, and the following cycle hanging=1 on rope 2.
- In COOLDOWN from rope 2, collision 6'b001100 → attach to rope 3 next cycle, grabPulse=1.
- SWING_FRAMES=4: dirToggle=6'b111111 for one cycle after startOfFrame pulses 4, 8, 12; zero otherwise.
- Assert resetN=0 while hanging with jumpReq=1 and startOfFrame=1 → next cycle all outputs 0, FSM FREE, frameCnt restarts.

Source files
------------

// File: rtl/rope_grab_controller.sv
// Rope grab arbitration and swing scheduler: picks the one rope the monkey hangs on,
// forwards that rope's speed, enforces a re-grab cooldown on release, and pulses swing reversals.
module rope_grab_controller #(
  parameter int unsigned ROPES           = 6,
  parameter int unsigned SWING_FRAMES    = 60,
  parameter int unsigned COOLDOWN_FRAMES = 15
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      startOfFrame,
  input  logic [ROPES-1:0]          monkeyCollision,
  input  logic [ROPES*32-1:0]       ropeSpeeds,
  input  logic                      jumpReq,
  output logic                      hanging,
  output logic [$clog2(ROPES)-1:0]  ropeIdx,
  output logic [31:0]               carrySpeed,
  output logic                      grabPulse,
  output logic [ROPES-1:0]          dirToggle
);

  localparam int unsigned IW = $clog2(ROPES);
  localparam int unsigned FW = (SWING_FRAMES > 1) ? $clog2(SWING_FRAMES) : 1;
  localparam int unsigned CW = $clog2(COOLDOWN_FRAMES + 1);

  typedef enum logic [1:0] {
    ST_FREE,
    ST_HANGING,
    ST_COOLDOWN
  } state_e;

  state_e             state_q, state_d;
  logic [FW-1:0]      frame_cnt_q, frame_cnt_d;
  logic [CW-1:0]      cool_cnt_q, cool_cnt_d;
  logic               hanging_q, hanging_d;
  logic [IW-1:0]      rope_idx_q, rope_idx_d;
  logic [31:0]        carry_q, carry_d;
  logic               grab_q, grab_d;
  logic [ROPES-1:0]   dir_q, dir_d;

  logic [ROPES-1:0]   cand_mask;
  logic [IW-1:0]      winner;
  logic               cand_any;

  function automatic logic [31:0] speed_of(input logic [IW-1:0] idx);
    return ropeSpeeds[32*int'(idx) +: 32];
  endfunction

  // The released rope is masked only while cooling down; FREE accepts any rope.
  always_comb begin
    cand_mask = monkeyCollision;
    if (state_q == ST_COOLDOWN) begin
      cand_mask = monkeyCollision & ~(ROPES'(1) << rope_idx_q);
    end
    winner   = '0;
    cand_any = 1'b0;
    for (int unsigned i = 0; i < ROPES; i++) begin
      if (cand_mask[i] && !cand_any) begin
        winner   = IW'(i);
        cand_any = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cool_cnt_d = cool_cnt_q;
    hanging_d  = hanging_q;
    rope_idx_d = rope_idx_q;
    carry_d    = carry_q;
    grab_d     = 1'b0;

    case (state_q)
      ST_FREE: begin
        hanging_d = 1'b0;
        carry_d   = '0;
        if (cand_any) begin
          state_d    = ST_HANGING;
          hanging_d  = 1'b1;
          rope_idx_d = winner;
          carry_d    = speed_of(winner);
          grab_d     = 1'b1;
        end
      end

      ST_HANGING: begin
        if (jumpReq) begin
          state_d    = ST_COOLDOWN;
          hanging_d  = 1'b0;
          carry_d    = '0;
          cool_cnt_d = CW'(COOLDOWN_FRAMES);
        end else begin
          hanging_d = 1'b1;
          carry_d   = speed_of(rope_idx_q);
        end
      end

      ST_COOLDOWN: begin
        hanging_d = 1'b0;
        carry_d   = '0;
        // A grab on another rope wins over the countdown in the same cycle.
        if (cand_any) begin
          state_d    = ST_HANGING;
          hanging_d  = 1'b1;
          rope_idx_d = winner;
          carry_d    = speed_of(winner);
          grab_d     = 1'b1;
          cool_cnt_d = '0;
        end else if (startOfFrame) begin
          if (cool_cnt_q == CW'(1)) begin
            state_d    = ST_FREE;
            cool_cnt_d = '0;
          end else begin
            cool_cnt_d = cool_cnt_q - CW'(1);
          end
        end
      end

      default: begin
        state_d    = ST_FREE;
        hanging_d  = 1'b0;
        carry_d    = '0;
        cool_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    dir_d       = '0;
    if (startOfFrame) begin
      if (frame_cnt_q == FW'(SWING_FRAMES - 1)) begin
        frame_cnt_d = '0;
        dir_d       = '1;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= ST_FREE;
      frame_cnt_q <= '0;
      cool_cnt_q  <= '0;
      hanging_q   <= 1'b0;
      rope_idx_q  <= '0;
      carry_q     <= '0;
      grab_q      <= 1'b0;
      dir_q       <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      cool_cnt_q  <= cool_cnt_d;
      hanging_q   <= hanging_d;
      rope_idx_q  <= rope_idx_d;
      carry_q     <= carry_d;
      grab_q      <= grab_d;
      dir_q       <= dir_d;
    end
  end

  assign hanging    = hanging_q;
  assign ropeIdx    = rope_idx_q;
  assign carrySpeed = carry_q;
  assign grabPulse  = grab_q;
  assign dirToggle  = dir_q;

endmodule

// File: tb/tb_rope_grab_controller.sv
// Bench for rope_grab_controller: directed scenarios plus randomized traffic checked
// against a frame-counting behavioural model of the grab/cooldown/swing rules.
module tb_rope_grab_controller;

  localparam int R  = 6;
  localparam int SW = 4;
  localparam int CD = 15;
  localparam int IW = $clog2(R);

  logic                 clk = 1'b0;
  logic                 resetN;
  logic                 startOfFrame;
  logic [R-1:0]         monkeyCollision;
  logic [R*32-1:0]      ropeSpeeds;
  logic                 jumpReq;
  logic                 hanging;
  logic [IW-1:0]        ropeIdx;
  logic [31:0]          carrySpeed;
  logic                 grabPulse;
  logic [R-1:0]         dirToggle;

  logic signed [31:0]   spd [R];

  int vectors = 0;
  int errors  = 0;

  // reference model state
  bit                 m_att;
  int                 m_last;
  int                 m_rem;
  int                 m_sof;
  logic signed [31:0] m_carry;
  logic               m_grab;
  logic [R-1:0]       m_dir;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < R; i++) ropeSpeeds[i*32 +: 32] = spd[i];
  end

  rope_grab_controller #(
    .ROPES(R),
    .SWING_FRAMES(SW),
    .COOLDOWN_FRAMES(CD)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .monkeyCollision(monkeyCollision),
    .ropeSpeeds(ropeSpeeds),
    .jumpReq(jumpReq),
    .hanging(hanging),
    .ropeIdx(ropeIdx),
    .carrySpeed(carrySpeed),
    .grabPulse(grabPulse),
    .dirToggle(dirToggle)
  );

  // Advance one clock, step the model with the inputs seen at that edge, settle 1 time unit.
  task automatic tick();
    int win;
    @(posedge clk);
    if (!resetN) begin
      m_att = 0; m_last = 0; m_rem = 0; m_sof = 0;
      m_carry = 0; m_grab = 0; m_dir = '0;
    end else begin
      m_grab = 0;
      m_dir  = '0;
      if (startOfFrame) begin
        m_sof++;
        if (m_sof % SW == 0) m_dir = '1;
      end
      if (m_att) begin
        if (jumpReq) begin
          m_att = 0; m_rem = CD; m_carry = 0;
        end else begin
          m_carry = spd[m_last];
        end
      end else begin
        win = -1;
        for (int i = 0; i < R; i++)
          if (monkeyCollision[i] && !(m_rem > 0 && i == m_last) && win < 0) win = i;
        if (win >= 0) begin
          m_att = 1; m_last = win; m_carry = spd[win]; m_grab = 1; m_rem = 0;
        end else begin
          m_carry = 0;
          if (m_rem > 0 && startOfFrame) m_rem--;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    resetN = 1'b0; startOfFrame = 1'b0; jumpReq = 1'b0; monkeyCollision = '0;
    for (int i = 0; i < R; i++) spd[i] = 32'sd100 + i;
    tick(); tick();
    vectors++; if (hanging !== 1'b0) begin errors++; $display("FAIL reset_hanging: got %0b want 0", hanging); end
    vectors++; if (ropeIdx !== '0) begin errors++; $display("FAIL reset_idx: got %0d want 0", ropeIdx); end
    vectors++; if (carrySpeed !== '0) begin errors++; $display("FAIL reset_carry: got %0d want 0", $signed(carrySpeed)); end
    vectors++; if (grabPulse !== 1'b0) begin errors++; $display("FAIL reset_grab: got %0b want 0", grabPulse); end
    vectors++; if (dirToggle !== '0) begin errors++; $display("FAIL reset_dir: got %b want 0", dirToggle); end
  endtask

  task automatic test_grab();
    resetN = 1'b1;
    spd[2] = -32'sd5;
    monkeyCollision = 6'b010100;
    tick();
    vectors++; if (hanging !== 1'b1) begin errors++; $display("FAIL grab_hanging: got %0b want 1", hanging); end
    vectors++; if (ropeIdx !== IW'(2)) begin errors++; $display("FAIL grab_idx: got %0d want 2", ropeIdx); end
    vectors++; if ($signed(carrySpeed) !== -32'sd5) begin errors++; $display("FAIL grab_carry: got %0d want -5", $signed(carrySpeed)); end
    vectors++; if (grabPulse !== 1'b1) begin errors++; $display("FAIL grab_pulse: got %0b want 1", grabPulse); end
    monkeyCollision = '0;
    tick();
    vectors++; if (grabPulse !== 1'b0) begin errors++; $display("FAIL grab_pulse_clear: got %0b want 0", grabPulse); end
    vectors++; if (hanging !== 1'b1) begin errors++; $display("FAIL grab_hold: got %0b want 1", hanging); end
  endtask

  task automatic test_carry_track();
    spd[2] = 32'sd7;
    spd[0] = 32'sd99;
    monkeyCollision = 6'b000001;
    tick();
    vectors++; if ($signed(carrySpeed) !== 32'sd7) begin errors++; $display("FAIL track_carry: got %0d want 7", $signed(carrySpeed)); end
    vectors++; if (ropeIdx !== IW'(2)) begin errors++; $display("FAIL track_idx: got %0d want 2", ropeIdx); end
    vectors++; if (grabPulse !== 1'b0) begin errors++; $display("FAIL track_nograb: got %0b want 0", grabPulse); end
    monkeyCollision = '0;
  endtask

  task automatic test_cooldown();
    monkeyCollision = 6'b000100;
    jumpReq = 1'b1;
    tick();
    vectors++; if (hanging !== 1'b0) begin errors++; $display("FAIL jump_hanging: got %0b want 0", hanging); end
    vectors++; if (carrySpeed !== '0) begin errors++; $display("FAIL jump_carry: got %0d want 0", $signed(carrySpeed)); end
    vectors++; if (ropeIdx !== IW'(2)) begin errors++; $display("FAIL jump_idx: got %0d want 2", ropeIdx); end
    jumpReq = 1'b0;
    for (int f = 1; f <= CD; f++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      vectors++; if (hanging !== 1'b0) begin errors++; $display("FAIL cool_hold_f%0d: got %0b want 0", f, hanging); end
      if (f < CD) begin
        for (int k = 0; k < 2; k++) begin
          tick();
          vectors++; if (hanging !== 1'b0) begin errors++; $display("FAIL cool_gap_f%0d: got %0b want 0", f, hanging); end
        end
      end
    end
    tick();
    vectors++; if (hanging !== 1'b1) begin errors++; $display("FAIL cool_regrab: got %0b want 1", hanging); end
    vectors++; if (ropeIdx !== IW'(2)) begin errors++; $display("FAIL cool_regrab_idx: got %0d want 2", ropeIdx); end
    vectors++; if (grabPulse !== 1'b1) begin errors++; $display("FAIL cool_regrab_pulse: got %0b want 1", grabPulse); end
    monkeyCollision = '0;
    tick();
  endtask

  task automatic test_cooldown_other();
    jumpReq = 1'b1;
    tick();
    jumpReq = 1'b0;
    spd[3] = -32'sd1234;
    monkeyCollision = 6'b001100;
    tick();
    vectors++; if (hanging !== 1'b1) begin errors++; $display("FAIL other_hanging: got %0b want 1", hanging); end
    vectors++; if (ropeIdx !== IW'(3)) begin errors++; $display("FAIL other_idx: got %0d want 3", ropeIdx); end
    vectors++; if (grabPulse !== 1'b1) begin errors++; $display("FAIL other_pulse: got %0b want 1", grabPulse); end
    vectors++; if ($signed(carrySpeed) !== -32'sd1234) begin errors++; $display("FAIL other_carry: got %0d want -1234", $signed(carrySpeed)); end
    monkeyCollision = '0;
  endtask

  task automatic test_swing();
    logic [R-1:0] want;
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    for (int p = 1; p <= 13; p++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      want = (p % SW == 0) ? {R{1'b1}} : {R{1'b0}};
      vectors++; if (dirToggle !== want) begin errors++; $display("FAIL swing_p%0d: got %b want %b", p, dirToggle, want); end
      tick();
      vectors++; if (dirToggle !== '0) begin errors++; $display("FAIL swing_gap_p%0d: got %b want 0", p, dirToggle); end
    end
  endtask

  task automatic test_reset_mid();
    logic [R-1:0] want;
    spd[1] = 32'sd42;
    monkeyCollision = 6'b000010;
    startOfFrame = 1'b1;
    tick();
    monkeyCollision = '0;
    startOfFrame = 1'b0;
    vectors++; if (hanging !== 1'b1) begin errors++; $display("FAIL mid_pre_hang: got %0b want 1", hanging); end
    resetN = 1'b0; jumpReq = 1'b1; startOfFrame = 1'b1;
    tick();
    vectors++; if ({hanging, ropeIdx, carrySpeed, grabPulse, dirToggle} !== '0)
      begin errors++; $display("FAIL mid_reset: got h=%0b i=%0d c=%0d g=%0b d=%b want all 0", hanging, ropeIdx, $signed(carrySpeed), grabPulse, dirToggle); end
    resetN = 1'b1; jumpReq = 1'b0; startOfFrame = 1'b0;
    tick();
    for (int p = 1; p <= SW; p++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      want = (p == SW) ? {R{1'b1}} : {R{1'b0}};
      vectors++; if (dirToggle !== want) begin errors++; $display("FAIL mid_swing_p%0d: got %b want %b", p, dirToggle, want); end
      vectors++; if (hanging !== 1'b0) begin errors++; $display("FAIL mid_free_p%0d: got %0b want 0", p, hanging); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4000; n++) begin
      resetN          = ($urandom_range(0, 299) != 0);
      startOfFrame    = ($urandom_range(0, 3) == 0);
      jumpReq         = ($urandom_range(0, 9) == 0);
      monkeyCollision = ($urandom_range(0, 2) == 0) ? R'($urandom) : '0;
      spd[$urandom_range(0, R-1)] = $signed($urandom);
      tick();
      vectors++; if (hanging !== logic'(m_att)) begin errors++; $display("FAIL rnd_hanging@%0d: got %0b want %0b", n, hanging, m_att); end
      vectors++; if (ropeIdx !== IW'(m_last)) begin errors++; $display("FAIL rnd_idx@%0d: got %0d want %0d", n, ropeIdx, m_last); end
      vectors++; if ($signed(carrySpeed) !== m_carry) begin errors++; $display("FAIL rnd_carry@%0d: got %0d want %0d", n, $signed(carrySpeed), m_carry); end
      vectors++; if (grabPulse !== m_grab) begin errors++; $display("FAIL rnd_grab@%0d: got %0b want %0b", n, grabPulse, m_grab); end
      vectors++; if (dirToggle !== m_dir) begin errors++; $display("FAIL rnd_dir@%0d: got %b want %b", n, dirToggle, m_dir); end
    end
  endtask

  initial begin
    test_reset();
    test_grab();
    test_carry_track();
    test_cooldown();
    test_cooldown_other();
    test_swing();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
